// File: rtl/tx_ethernet.sv
`default_nettype none
// ============================================================================
//  Module   : tx_ethernet
//  Purpose  : GMII Ethernet frame transmitter. A one-cycle tx_start in IDLE
//             latches the header fields and sends preamble, SFD, DST, SRC,
//             EtherType, the streamed payload, optional zero padding and a
//             CRC-32 FCS, followed by an IFG-cycle inter-frame gap.
//  Macro    : TX_PAD_EN - when defined, payloads shorter than 46 bytes are
//             zero-padded to 46 bytes; otherwise FCS follows the payload.
//  Ports    : RX_CLK, rst            clock / synchronous active-high reset
//             mac_addr, tx_mac_dst   source / destination MAC (48 bit)
//             tx_ethertype           EtherType (16 bit)
//             tx_start               one-cycle frame request
//             tx_payload[_v,_last]   payload stream, tx_payload_ready = take
//             tx_busy, tx_irq,       status: busy, frame-done pulse,
//             tx_err                 underflow / oversize pulse
//             TX_EN, TXD, TX_ER      registered GMII transmit outputs
//  Revision : 1.0 - initial release
// ============================================================================
module tx_ethernet #(
    parameter int             OCT = 8,
    parameter logic [OCT-1:0] PRE = 8'b10101010,
    parameter logic [OCT-1:0] SFD = 8'b10101011,
    parameter int             IFG = 12
) (
    input  logic           RX_CLK,
    input  logic           rst,
    input  logic [47:0]    mac_addr,
    input  logic [47:0]    tx_mac_dst,
    input  logic [15:0]    tx_ethertype,
    input  logic           tx_start,
    input  logic [OCT-1:0] tx_payload,
    input  logic           tx_payload_v,
    input  logic           tx_payload_last,
    output logic           tx_payload_ready,
    output logic           tx_busy,
    output logic           tx_irq,
    output logic           tx_err,
    output logic           TX_EN,
    output logic [OCT-1:0] TXD,
    output logic           TX_ER
);

    localparam int CW = (IFG > 8) ? $clog2(IFG) + 1 : 4;

    localparam logic [CW-1:0] c_pre_last = CW'(5);
    localparam logic [CW-1:0] c_mac_last = CW'(5);
    localparam logic [CW-1:0] c_typ_last = CW'(1);
    localparam logic [CW-1:0] c_fcs_last = CW'(3);
    localparam logic [CW-1:0] c_gap_last = CW'(IFG - 1);
    localparam logic [10:0]   c_max_pay  = 11'd1500;
    localparam logic [10:0]   c_min_pay  = 11'd46;

    // The state names the phase of the byte driven onto TXD at the NEXT edge,
    // so PAYLOAD is the state in which tx_payload_ready is high.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_PREAMBLE = 4'd1,
        S_SFD      = 4'd2,
        S_DST      = 4'd3,
        S_SRC      = 4'd4,
        S_TYPE     = 4'd5,
        S_PAYLOAD  = 4'd6,
        S_PAD      = 4'd7,
        S_FCS      = 4'd8,
        S_GAP      = 4'd9
    } state_t;

    state_t         state_q,    state_d;
    logic [CW-1:0]  cnt_q,      cnt_d;
    logic [10:0]    pay_cnt_q,  pay_cnt_d;
    logic [31:0]    crc_q,      crc_d;
    logic [47:0]    dst_q,      dst_d;
    logic [47:0]    src_q,      src_d;
    logic [15:0]    type_q,     type_d;
    logic           irq_pend_q, irq_pend_d;
    logic           busy_q,     busy_d;
    logic           ready_q,    ready_d;
    logic           irq_q,      irq_d;
    logic           err_q,      err_d;
    logic           tx_en_q,    tx_en_d;
    logic           tx_er_q,    tx_er_d;
    logic [OCT-1:0] txd_q,      txd_d;

    // Reflected CRC-32 (polynomial 0x04C11DB7 bit-reversed), LSB of data first.
    function automatic logic [31:0] crc_next(input logic [31:0] crc,
                                             input logic [OCT-1:0] data);
        logic [31:0] c;
        c = crc ^ {{(32-OCT){1'b0}}, data};
        for (int i = 0; i < OCT; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pay_cnt_d  = pay_cnt_q;
        crc_d      = crc_q;
        dst_d      = dst_q;
        src_d      = src_q;
        type_d     = type_q;
        busy_d     = busy_q;
        irq_pend_d = 1'b0;
        irq_d      = irq_pend_q;
        err_d      = 1'b0;
        tx_en_d    = 1'b0;
        tx_er_d    = 1'b0;
        txd_d      = '0;

        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    dst_d     = tx_mac_dst;
                    src_d     = mac_addr;
                    type_d    = tx_ethertype;
                    busy_d    = 1'b1;
                    crc_d     = 32'hFFFF_FFFF;
                    pay_cnt_d = '0;
                    cnt_d     = '0;
                    tx_en_d   = 1'b1;
                    txd_d     = PRE;
                    state_d   = S_PREAMBLE;
                end
            end
            // The first preamble byte leaves from IDLE; six more follow here.
            S_PREAMBLE: begin
                tx_en_d = 1'b1;
                txd_d   = PRE;
                if (cnt_q == c_pre_last) begin
                    cnt_d   = '0;
                    state_d = S_SFD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SFD: begin
                tx_en_d = 1'b1;
                txd_d   = SFD;
                state_d = S_DST;
            end
            // Header fields shift left so the top byte is always the next one.
            S_DST: begin
                tx_en_d = 1'b1;
                txd_d   = dst_q[47:40];
                crc_d   = crc_next(crc_q, dst_q[47:40]);
                dst_d   = {dst_q[39:0], 8'h00};
                if (cnt_q == c_mac_last) begin
                    cnt_d   = '0;
                    state_d = S_SRC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SRC: begin
                tx_en_d = 1'b1;
                txd_d   = src_q[47:40];
                crc_d   = crc_next(crc_q, src_q[47:40]);
                src_d   = {src_q[39:0], 8'h00};
                if (cnt_q == c_mac_last) begin
                    cnt_d   = '0;
                    state_d = S_TYPE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_TYPE: begin
                tx_en_d = 1'b1;
                txd_d   = type_q[15:8];
                crc_d   = crc_next(crc_q, type_q[15:8]);
                type_d  = {type_q[7:0], 8'h00};
                if (cnt_q == c_typ_last) begin
                    cnt_d   = '0;
                    state_d = S_PAYLOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PAYLOAD: begin
                tx_en_d = 1'b1;
                if (tx_payload_v) begin
                    txd_d     = tx_payload;
                    crc_d     = crc_next(crc_q, tx_payload);
                    pay_cnt_d = pay_cnt_q + 1'b1;
                    // The 1500th byte closes the frame even without a last flag.
                    if (tx_payload_last || (pay_cnt_d == c_max_pay)) begin
                        err_d = (pay_cnt_d == c_max_pay) && !tx_payload_last;
                        cnt_d = '0;
`ifdef TX_PAD_EN
                        state_d = (pay_cnt_d < c_min_pay) ? S_PAD : S_FCS;
`else
                        state_d = S_FCS;
`endif
                    end
                end else begin
                    // Underflow: one errored cycle, no FCS, straight to the gap.
                    tx_er_d = 1'b1;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_PAD: begin
                tx_en_d   = 1'b1;
                txd_d     = '0;
                crc_d     = crc_next(crc_q, '0);
                pay_cnt_d = pay_cnt_q + 1'b1;
                if (pay_cnt_d == c_min_pay) begin
                    cnt_d   = '0;
                    state_d = S_FCS;
                end
            end
            // FCS is the complemented register, low byte first; shift it down.
            S_FCS: begin
                tx_en_d = 1'b1;
                txd_d   = ~crc_q[7:0];
                crc_d   = {8'h00, crc_q[31:8]};
                if (cnt_q == c_fcs_last) begin
                    cnt_d      = '0;
                    irq_pend_d = 1'b1;
                    state_d    = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == c_gap_last) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        ready_d = (state_d == S_PAYLOAD);
    end

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pay_cnt_q  <= '0;
            crc_q      <= 32'hFFFF_FFFF;
            dst_q      <= '0;
            src_q      <= '0;
            type_q     <= '0;
            irq_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            irq_q      <= 1'b0;
            err_q      <= 1'b0;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            txd_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pay_cnt_q  <= pay_cnt_d;
            crc_q      <= crc_d;
            dst_q      <= dst_d;
            src_q      <= src_d;
            type_q     <= type_d;
            irq_pend_q <= irq_pend_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            irq_q      <= irq_d;
            err_q      <= err_d;
            tx_en_q    <= tx_en_d;
            tx_er_q    <= tx_er_d;
            txd_q      <= txd_d;
        end
    end

    assign tx_payload_ready = ready_q;
    assign tx_busy          = busy_q;
    assign tx_irq           = irq_q;
    assign tx_err           = err_q;
    assign TX_EN            = tx_en_q;
    assign TX_ER            = tx_er_q;
    assign TXD              = txd_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_ethernet.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_ethernet
//  Purpose  : Self-checking bench for tx_ethernet. Each frame's expected GMII
//             byte stream is built from the Ethernet frame layout and a
//             bit-serial CRC-32, then compared with what the DUT transmits.
//             Honours TX_PAD_EN the same way as the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tx_ethernet;

    localparam int IFG = 12;
`ifdef TX_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    logic        RX_CLK = 1'b0;
    logic        rst;
    logic [47:0] mac_addr;
    logic [47:0] tx_mac_dst;
    logic [15:0] tx_ethertype;
    logic        tx_start;
    logic [7:0]  tx_payload;
    logic        tx_payload_v;
    logic        tx_payload_last;
    logic        tx_payload_ready;
    logic        tx_busy;
    logic        tx_irq;
    logic        tx_err;
    logic        TX_EN;
    logic [7:0]  TXD;
    logic        TX_ER;

    always #5 RX_CLK = ~RX_CLK;

    tx_ethernet dut (
        .RX_CLK          (RX_CLK),
        .rst             (rst),
        .mac_addr        (mac_addr),
        .tx_mac_dst      (tx_mac_dst),
        .tx_ethertype    (tx_ethertype),
        .tx_start        (tx_start),
        .tx_payload      (tx_payload),
        .tx_payload_v    (tx_payload_v),
        .tx_payload_last (tx_payload_last),
        .tx_payload_ready(tx_payload_ready),
        .tx_busy         (tx_busy),
        .tx_irq          (tx_irq),
        .tx_err          (tx_err),
        .TX_EN           (TX_EN),
        .TXD             (TXD),
        .TX_ER           (TX_ER)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] pay [0:1599];
    logic [7:0] got [$];
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Textbook reflected CRC-32, one bit at a time.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic build_exp(input int n, input int drop_at);
        int          eff;
        logic [31:0] c;
        exp_q.delete();
        repeat (7) exp_q.push_back(8'hAA);
        exp_q.push_back(8'hAB);
        for (int i = 5; i >= 0; i--) exp_q.push_back(tx_mac_dst[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) exp_q.push_back(mac_addr[i*8 +: 8]);
        exp_q.push_back(tx_ethertype[15:8]);
        exp_q.push_back(tx_ethertype[7:0]);
        if (drop_at >= 0) begin
            for (int i = 0; i < drop_at; i++) exp_q.push_back(pay[i]);
            exp_q.push_back(8'h00);
        end else begin
            eff = (n > 1500) ? 1500 : n;
            for (int i = 0; i < eff; i++) exp_q.push_back(pay[i]);
            if (PAD_ON && eff < 46) repeat (46 - eff) exp_q.push_back(8'h00);
            c = 32'hFFFF_FFFF;
            for (int i = 8; i < exp_q.size(); i++) c = crc_step(c, exp_q[i]);
            c = ~c;
            for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
        end
    endtask

    // Called at a falling edge; requests a frame and follows it to the end of
    // the gap (or, with rst_at >= 0, pulses reset at that cycle and observes).
    task automatic send_frame(input string nm, input int n, input int drop_at,
                              input bit hold, input int rst_at);
        int idx = 0, en_cnt = 0, rises = 0, first_en = -1, last_en = -1;
        int irq_n = 0, irq_k = -1, err_n = 0, er_n = 0, er_k = -1;
        int rdy_n = 0, acc_n = 0, drop_k = -1, post_rst_en = 0, mism = -1;
        bit prev_en = 1'b0, done = 1'b0;

        build_exp(n, drop_at);
        got.delete();
        tx_start        = 1'b1;
        tx_payload_v    = 1'b0;
        tx_payload_last = 1'b0;

        for (int k = 1; k <= 2000; k++) begin
            @(negedge RX_CLK);
            if (k == 1) begin
                check({nm, "/busy_on_start"}, 64'(tx_busy), 64'd1);
                check({nm, "/txen_on_start"}, 64'(TX_EN), 64'd1);
            end
            if (TX_EN) begin
                got.push_back(TXD);
                en_cnt++;
                if (!prev_en) rises++;
                if (first_en < 0) first_en = k;
                last_en = k;
            end
            prev_en = TX_EN;
            if (tx_irq) begin irq_n++; irq_k = k; end
            if (tx_err) err_n++;
            if (TX_ER) begin er_n++; er_k = k; end
            if (tx_payload_ready) rdy_n++;
            if (rst_at >= 0 && k == rst_at + 1) begin
                check({nm, "/txen_after_rst"}, 64'(TX_EN), 64'd0);
                check({nm, "/busy_after_rst"}, 64'(tx_busy), 64'd0);
                check({nm, "/ready_after_rst"}, 64'(tx_payload_ready), 64'd0);
            end
            if (rst_at >= 0 && k > rst_at && TX_EN) post_rst_en++;
            if (rst_at < 0 && last_en > 0 && !tx_busy) begin
                drop_k = k;
                done   = 1'b1;
                break;
            end
            if (rst_at >= 0 && k == rst_at + 20) begin
                done = 1'b1;
                break;
            end
            rst      = (rst_at >= 0 && k == rst_at);
            tx_start = hold;
            if (tx_payload_ready) begin
                tx_payload      = pay[idx];
                tx_payload_last = (idx == n - 1);
                tx_payload_v    = (idx != drop_at);
                if (tx_payload_v) begin idx++; acc_n++; end
            end else begin
                tx_payload      = 8'($urandom);
                tx_payload_v    = 1'b0;
                tx_payload_last = 1'b0;
            end
        end
        tx_payload_v = 1'b0;
        check({nm, "/finished"}, 64'(done), 64'd1);

        if (rst_at >= 0) begin
            check({nm, "/txen_post_rst"}, 64'(post_rst_en), 64'd0);
            check({nm, "/irq_count"}, 64'(irq_n), 64'd0);
            check({nm, "/err_count"}, 64'(err_n), 64'd0);
            return;
        end

        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (mism < 0 && got[i] !== exp_q[i]) mism = i;
        check({nm, "/length"}, 64'(got.size()), 64'(exp_q.size()));
        check({nm, "/first_bad_byte"}, 64'(mism), 64'(-1));
        check({nm, "/txen_bursts"}, 64'(rises), 64'd1);
        check({nm, "/first_en"}, 64'(first_en), 64'd1);
        check({nm, "/er_count"}, 64'(er_n), 64'((drop_at >= 0) ? 1 : 0));
        check({nm, "/err_count"}, 64'(err_n), 64'((drop_at >= 0 || n > 1500) ? 1 : 0));
        check({nm, "/ready_cycles"}, 64'(rdy_n), 64'(acc_n + ((drop_at >= 0) ? 1 : 0)));
        check({nm, "/busy_release"}, 64'(drop_k), 64'(last_en + IFG));
        if (drop_at >= 0) begin
            check({nm, "/er_cycle"}, 64'(er_k), 64'(last_en));
            check({nm, "/irq_count"}, 64'(irq_n), 64'd0);
        end else begin
            check({nm, "/irq_count"}, 64'(irq_n), 64'd1);
            check({nm, "/irq_cycle"}, 64'(irq_k), 64'(last_en + 1));
        end
    endtask

    task automatic rand_frame_data();
        tx_mac_dst   = {16'($urandom), 32'($urandom)};
        mac_addr     = {16'($urandom), 32'($urandom)};
        tx_ethertype = 16'($urandom);
        for (int i = 0; i < 1600; i++) pay[i] = 8'($urandom);
    endtask

    initial begin
        logic [31:0] res;
        rst             = 1'b1;
        tx_start        = 1'b0;
        tx_payload      = 8'h00;
        tx_payload_v    = 1'b0;
        tx_payload_last = 1'b0;
        tx_mac_dst      = '0;
        mac_addr        = '0;
        tx_ethertype    = '0;
        repeat (3) @(negedge RX_CLK);
        check("reset/TX_EN", 64'(TX_EN), 64'd0);
        check("reset/TXD", 64'(TXD), 64'd0);
        check("reset/TX_ER", 64'(TX_ER), 64'd0);
        check("reset/busy", 64'(tx_busy), 64'd0);
        check("reset/ready", 64'(tx_payload_ready), 64'd0);
        check("reset/irq_err", 64'({tx_irq, tx_err}), 64'd0);
        rst = 1'b0;
        @(negedge RX_CLK);

        // Broadcast frame with 46 counting bytes; then the FCS residue.
        tx_mac_dst   = 48'hFFFF_FFFF_FFFF;
        mac_addr     = 48'h0200_0000_0001;
        tx_ethertype = 16'h0800;
        for (int i = 0; i < 46; i++) pay[i] = 8'(i);
        send_frame("bcast46", 46, -1, 1'b0, -1);
        check("bcast46/txen_cycles", 64'(got.size()), 64'd72);
        res = 32'hFFFF_FFFF;
        for (int i = 8; i < got.size(); i++) res = crc_step(res, got[i]);
        check("bcast46/crc_residue", 64'(res), 64'hDEBB20E3);

        // Single-byte payload.
        pay[0] = 8'hAB;
        send_frame("one_byte", 1, -1, 1'b0, -1);
        check("one_byte/txen_cycles", 64'(got.size()), PAD_ON ? 64'd72 : 64'd27);

        // Underflow at payload byte 10.
        rand_frame_data();
        send_frame("underflow", 30, 10, 1'b0, -1);

        // tx_start held through a frame and its gap, then a back-to-back frame.
        rand_frame_data();
        send_frame("hold_a", $urandom_range(1, 60), -1, 1'b1, -1);
        rand_frame_data();
        send_frame("hold_b", $urandom_range(1, 60), -1, 1'b0, -1);

        // Reset pulsed while the source address is going out.
        rand_frame_data();
        send_frame("rst_src", 40, -1, 1'b0, 16);
        rand_frame_data();
        send_frame("after_rst", 50, -1, 1'b0, -1);

        // Random frames.
        for (int f = 0; f < 4; f++) begin
            rand_frame_data();
            send_frame("random", $urandom_range(1, 120), -1, 1'b0, -1);
        end

        // Oversize: no last flag before byte 1500.
        rand_frame_data();
        send_frame("oversize", 1600, -1, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
